// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32 M-extension iterative multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  // funct3 encodings; bit 2 selects divide, for divides bit 1 selects
  // remainder and bit 0 selects unsigned.
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Sequencer state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Architecturally defined special results (32-bit view).
  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the shared 2*XLEN accumulator.
// Multiply: acc = {partial_hi, multiplier_remaining}; add multiplicand to the
// upper half when the current multiplier bit is set, then shift right.
// Divide: acc = {partial_remainder, dividend_remaining/quotient}; shift left,
// trial-subtract the divisor, and shift in the quotient bit.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opb,
  input  logic              i_is_div,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_rem_sh;
  logic [XLEN:0] w_diff;

  // Both algorithms computed side by side; is_div picks the next accumulator.
  always_comb begin
    w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opb} : '0);
    w_rem_sh = i_acc[2*XLEN-1:XLEN-1];
    // Borrow out (bit XLEN) means the trial subtract failed; the running
    // remainder is always below the divisor, so no other overflow is possible.
    w_diff   = w_rem_sh - {1'b0, i_opb};
    if (i_is_div) begin
      if (!w_diff[XLEN]) o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
      else               o_acc = {w_rem_sh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
    end else begin
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32 M-extension unit: sign-magnitude front end, XLEN shift-add or
// restoring-divide steps, then sign fix-up and half/quotient/remainder select.
// Handshake: start is sampled only in IDLE; stall holds the pipeline from the
// launch cycle through FIX; done is a one-cycle pulse with result valid.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] W_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        r_state;
  logic [2:0]        r_f3;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opb;
  logic              r_neg_main;
  logic              r_neg_rem;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_is_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_special;
  logic              w_div0, w_ovf, w_fast, w_launch;
  logic [2*XLEN-1:0] w_step, w_prod;
  logic [XLEN-1:0]   w_quot, w_rem, w_fix;
  logic [1:0]        w_next;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_acc    (r_acc),
    .i_opb    (r_opb),
    .i_is_div (r_f3[2]),
    .o_acc    (w_step)
  );

  // Launch decode: operand signedness, magnitudes and special-case detection.
  always_comb begin
    w_is_div  = funct3[2];
    w_sgn_a   = w_is_div ? ~funct3[0] : (funct3 != F3_MULHU);
    w_sgn_b   = w_is_div ? ~funct3[0] : ~funct3[1];
    w_neg_a   = w_sgn_a & rs1[XLEN-1];
    w_neg_b   = w_sgn_b & rs2[XLEN-1];
    w_mag_a   = w_neg_a ? -rs1 : rs1;
    w_mag_b   = w_neg_b ? -rs2 : rs2;
    w_div0    = (rs2 == '0);
    w_ovf     = ~funct3[0] & (rs1 == W_INT_MIN) & (rs2 == '1);
    w_fast    = FAST_SPECIAL & w_is_div & (w_div0 | w_ovf);
    w_launch  = (r_state == ST_IDLE) & start & ~flush;
    if (w_div0) w_special = funct3[1] ? rs1 : '1;
    else        w_special = funct3[1] ? '0 : W_INT_MIN;
  end

  // Final sign correction and selection of the architectural result.
  always_comb begin
    w_prod = r_neg_main ? -r_acc : r_acc;
    w_quot = r_neg_main ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_rem  = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    if (r_f3[2])             w_fix = r_f3[1] ? w_rem : w_quot;
    else if (r_f3 == F3_MUL) w_fix = w_prod[XLEN-1:0];
    else                     w_fix = w_prod[2*XLEN-1:XLEN];
  end

  // Next-state logic; flush wins over everything.
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (start) w_next = w_fast ? ST_DONE : ST_CALC;
        ST_CALC: if (r_cnt == '0) w_next = ST_FIX;
        ST_FIX:  w_next = ST_DONE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_f3       <= '0;
      r_acc      <= '0;
      r_opb      <= '0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
      r_done  <= (w_next == ST_DONE);
      if (w_launch) begin
        r_f3      <= funct3;
        r_acc     <= {{XLEN{1'b0}}, w_mag_a};
        r_opb     <= w_mag_b;
        // A zero divisor must leave the all-ones quotient un-negated.
        r_neg_main <= (w_neg_a ^ w_neg_b) & ~(w_is_div & w_div0);
        r_neg_rem  <= w_neg_a;
        r_cnt      <= CW'(XLEN - 1);
        if (w_fast) r_result <= w_special;
      end else if (!flush && r_state == ST_CALC) begin
        r_acc <= w_step;
        r_cnt <= r_cnt - 1'b1;
      end else if (!flush && r_state == ST_FIX) begin
        r_result <= w_fix;
      end
    end
  end

  assign stall     = w_launch | (r_state == ST_CALC) | (r_state == ST_FIX);
  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: two instances (fast special path on and off)
// share one stimulus stream; a vector table plus flush, reset and held-start
// sequences.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;

  logic        busy_f, stall_f, done_f, busy_s, stall_s, done_s;
  logic [31:0] result_f, result_s;
  logic [1:0]  state_f, state_s;

  int n_tests = 0;
  int n_fail  = 0;

  // run_op observations
  int          dc_s, dc_f, cnt_s, cnt_f, stall_cnt_s;
  logic [31:0] res_s, res_f;
  logic        stall0, busy35_s;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32), .FAST_SPECIAL(1'b1)) u_fast (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .flush(flush), .busy(busy_f), .stall(stall_f), .done(done_f),
    .result(result_f), .dbg_state(state_f)
  );

  muldiv_sequencer #(.XLEN(32), .FAST_SPECIAL(1'b0)) u_slow (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .flush(flush), .busy(busy_s), .stall(stall_s), .done(done_s),
    .result(result_s), .dbg_state(state_s)
  );

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge: cycle 0 is the launch cycle. Observes
  // both instances for 40 cycles; start stays high through hold_cycles and
  // operands are scrambled after launch to show they were captured.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int hold_cycles);
    dc_s = -1; dc_f = -1; cnt_s = 0; cnt_f = 0; stall_cnt_s = 0;
    res_s = '0; res_f = '0; busy35_s = 1'bx;
    funct3 = f3; rs1 = a; rs2 = b; start = 1'b1;
    @(negedge clk);
    stall0 = stall_s;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      rs1 = a ^ 32'h5A5A_00FF;
      rs2 = b ^ 32'h0F0F_1234;
      if (cyc > hold_cycles) start = 1'b0;
      @(negedge clk);
      if (done_s) begin
        cnt_s++;
        if (dc_s < 0) begin dc_s = cyc; res_s = result_s; end
      end
      if (done_f) begin
        cnt_f++;
        if (dc_f < 0) begin dc_f = cyc; res_f = result_f; end
      end
      if (stall_s) stall_cnt_s++;
      if (cyc == 35) busy35_s = busy_s;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] prior;
    int          dn_s, dn_f;

    vecs[0]  = '{"mul_7_m3",       F3_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{"mulh_min_min",   F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[2]  = '{"mulhu_ff_ff",    F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[3]  = '{"mulhsu_ff_ff",   F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{"div_m7_2",       F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{"rem_m7_2",       F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{"divu_100_7",     F3_DIVU,   32'd100,       32'd7,         32'd14,        1'b0};
    vecs[7]  = '{"remu_100_7",     F3_REMU,   32'd100,       32'd7,         32'd2,         1'b0};
    vecs[8]  = '{"divu_5_0",       F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{"remu_5_0",       F3_REMU,   32'd5,         32'd0,         32'd5,         1'b1};
    vecs[10] = '{"div_ovf",        F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[11] = '{"rem_ovf",        F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1};
    vecs[12] = '{"div_m5_0",       F3_DIV,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[13] = '{"rem_m5_0",       F3_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b1};
    vecs[14] = '{"mulh_3_m2",      F3_MULH,   32'd3,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0};
    vecs[15] = '{"div_7_m2",       F3_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
    vecs[16] = '{"rem_7_m2",       F3_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0};
    vecs[17] = '{"divu_ff_1",      F3_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0};

    // Clock/reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy",   {busy_s, busy_f},     32'd0);
    check("rst_done",   {done_s, done_f},     32'd0);
    check("rst_stall",  {stall_s, stall_f},   32'd0);
    check("rst_result", result_s | result_f,  32'd0);
    @(posedge clk);
    #1;

    // Table-driven vectors
    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, 0);
      check({vecs[i].name, "_res_slow"}, res_s, vecs[i].exp);
      check({vecs[i].name, "_res_fast"}, res_f, vecs[i].exp);
      check({vecs[i].name, "_lat_slow"}, dc_s, 32'd34);
      check({vecs[i].name, "_lat_fast"}, dc_f, vecs[i].special ? 32'd1 : 32'd34);
      check({vecs[i].name, "_ndone"},    cnt_s + cnt_f, 32'd2);
      check({vecs[i].name, "_stall0"},   stall0, 1'b1);
      check({vecs[i].name, "_stallcnt"}, stall_cnt_s, 32'd33);
      check({vecs[i].name, "_busy35"},   busy35_s, 1'b0);
    end

    // Flush at cycle 10 of a MUL, then relaunch at cycle 12
    prior = vecs[17].exp;
    dn_s = 0; dn_f = 0;
    funct3 = F3_MUL; rs1 = 32'd6; rs2 = 32'd9; start = 1'b1;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = (cyc == 10);
      @(negedge clk);
      if (done_s) dn_s++;
      if (done_f) dn_f++;
    end
    check("flush_busy",   {busy_s, busy_f},   32'd0);
    check("flush_state",  {state_s, state_f}, 32'd0);
    check("flush_ndone",  dn_s + dn_f,        32'd0);
    check("flush_res_s",  result_s,           prior);
    check("flush_res_f",  result_f,           prior);
    @(posedge clk);
    #1;
    run_op(F3_MUL, 32'd6, 32'd7, 0);
    check("relaunch_res", res_s, 32'd42);
    check("relaunch_cyc", dc_s + 12, 32'd46);

    // Asynchronous reset at cycle 20 of a DIV
    funct3 = F3_DIV; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    for (int cyc = 1; cyc <= 19; cyc++) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",   {busy_s, busy_f},     32'd0);
    check("arst_done",   {done_s, done_f},     32'd0);
    check("arst_stall",  {stall_s, stall_f},   32'd0);
    check("arst_result", result_s | result_f,  32'd0);
    check("arst_state",  {state_s, state_f},   32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    dn_s = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done_s || done_f) dn_s++;
    end
    check("arst_no_done", dn_s, 32'd0);
    @(posedge clk);
    #1;

    // start held through busy, operands changing: one done, launch operands used
    run_op(F3_DIVU, 32'd100, 32'd7, 34);
    check("hold_res_s",  res_s, 32'd14);
    check("hold_res_f",  res_f, 32'd14);
    check("hold_ndone",  cnt_s + cnt_f, 32'd2);
    check("hold_lat",    dc_s, 32'd34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
